// File: rtl/ntps_mdio_responder.sv
// Clause-22 MDIO responder: decodes manager frames sampled on synchronized MDC rises,
// answers reads by driving MDIO and forwards writes to a 32 x 16-bit register port.
module ntps_mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_MIN  = 32
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_tri,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        OP,
        PHYAD,
        REGAD,
        TA,
        RD_DATA,
        WR_DATA,
        SKIP
    } state_t;

    localparam logic [5:0] PRE_SAT = 6'(PRE_MIN);

    logic [2:0]  mdc_sync;
    logic [1:0]  mdio_sync;
    logic        rise;
    logic        sbit;

    state_t      state;
    logic [5:0]  ones_cnt;
    logic [4:0]  bit_cnt;
    logic        op_first;
    logic        op_read;
    logic        phy_match;
    logic [4:0]  addr_sh;
    logic [15:0] data_sh;
    logic        rd_latch;

    // mdc and mdio_i are asynchronous; the third mdc flop only feeds the edge detector.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
        end else begin
            mdc_sync  <= {mdc_sync[1:0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_i};
        end
    end

    assign rise = mdc_sync[1] & ~mdc_sync[2];
    assign sbit = mdio_sync[1];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            op_first    <= 1'b0;
            op_read     <= 1'b0;
            phy_match   <= 1'b0;
            addr_sh     <= '0;
            data_sh     <= '0;
            rd_latch    <= 1'b0;
            mdio_o      <= 1'b1;
            mdio_tri    <= 1'b1;
            reg_addr    <= '0;
            reg_rd_en   <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
        end else begin
            // NOTE: strobes default low every cycle so a single assignment below yields a one-cycle pulse.
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            rd_latch  <= reg_rd_en;
            if (rd_latch) begin
                data_sh <= reg_rd_data;
            end

            if (rise) begin
                case (state)
                    IDLE: begin
                        if (sbit) begin
                            if (ones_cnt != PRE_SAT) begin
                                ones_cnt <= ones_cnt + 6'd1;
                            end
                        end else begin
                            ones_cnt <= '0;
                            if (ones_cnt == PRE_SAT) begin
                                state <= START;
                            end
                        end
                    end

                    START: begin
                        bit_cnt <= '0;
                        state   <= sbit ? OP : IDLE;
                    end

                    OP: begin
                        op_first <= sbit;
                        if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            case ({op_first, sbit})
                                2'b10: begin
                                    op_read <= 1'b1;
                                    state   <= PHYAD;
                                end
                                2'b01: begin
                                    op_read <= 1'b0;
                                    state   <= PHYAD;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end

                    PHYAD: begin
                        addr_sh <= {addr_sh[3:0], sbit};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt   <= '0;
                            phy_match <= ({addr_sh[3:0], sbit} == PHY_ADDR);
                            state     <= REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    REGAD: begin
                        addr_sh <= {addr_sh[3:0], sbit};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= {addr_sh[3:0], sbit};
                            if (phy_match) begin
                                state     <= TA;
                                reg_rd_en <= op_read;
                            end else begin
                                state <= SKIP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    TA: begin
                        if (op_read) begin
                            if (bit_cnt == 5'd0) begin
                                bit_cnt  <= 5'd1;
                                mdio_tri <= 1'b0;
                                mdio_o   <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                mdio_o  <= data_sh[15];
                                data_sh <= {data_sh[14:0], 1'b0};
                                state   <= RD_DATA;
                            end
                        end else begin
                            // Write turnaround must be exactly 1 then 0.
                            if (bit_cnt == 5'd0) begin
                                bit_cnt <= 5'd1;
                                if (!sbit) begin
                                    bit_cnt <= '0;
                                    state   <= IDLE;
                                end
                            end else begin
                                bit_cnt <= '0;
                                state   <= sbit ? IDLE : WR_DATA;
                            end
                        end
                    end

                    RD_DATA: begin
                        if (bit_cnt == 5'd15) begin
                            bit_cnt  <= '0;
                            mdio_tri <= 1'b1;
                            mdio_o   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            mdio_o  <= data_sh[15];
                            data_sh <= {data_sh[14:0], 1'b0};
                        end
                    end

                    WR_DATA: begin
                        data_sh <= {data_sh[14:0], sbit};
                        if (bit_cnt == 5'd15) begin
                            bit_cnt     <= '0;
                            reg_wr_data <= {data_sh[14:0], sbit};
                            reg_wr_en   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    SKIP: begin
                        // Ride out TA plus 16 data bits of a frame addressed elsewhere.
                        if (bit_cnt == 5'd17) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    default: begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ntps_mdio_responder.md
# ntps_mdio_responder

Clause-22 MDIO responder (PHY-side management slave). It decodes management frames that an MDIO manager issues on the shared MDC/MDIO bus. It answers reads by driving MDIO, and forwards writes to a local 32 x 16-bit register port. It sits in a network path and feeds that path's mdio_out_n/mdio_tri_n pair into the MDIO merge mux. Its register port attaches to that path's PHY-status/control register bank.

## Interface
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PRE_MIN, 32, consecutive preamble ones required before a start (1..32).
- axi_aclk  in  1  system clock; all logic on rising edge.
- axi_aresetn  in  1  reset. Asynchronous assert, active-low.
- mdc  in  1  MDIO clock from manager. Asynchronous to axi_aclk; high and low phases each ≥ 5 axi_aclk cycles.
- mdio_i  in  1  MDIO line input (asynchronous).
- mdio_o  out  1  MDIO drive value.
- mdio_tri  out  1  1 = released (high-Z), 0 = drive mdio_o.
- reg_addr  out  5  register address; valid while reg_rd_en or reg_wr_en is high.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  16  read data, sampled exactly 1 cycle after reg_rd_en.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  16  write data; valid with reg_wr_en.

## Operation
- Input conditioning: mdc and mdio_i each pass through a 2-flop synchronizer. A third mdc flop gives edge detect. "rise" is a single-cycle pulse on a synchronized 0→1 transition of mdc. The bit sampled at a rise is the synchronized mdio_i in that same cycle.
- States: IDLE, START, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP. All transitions happen only on rise.
- IDLE: 5-bit-plus-saturating ones counter. It increments on each sampled 1 and saturates at PRE_MIN. A sampled 0 with count = PRE_MIN → START. A sampled 0 with count < PRE_MIN → counter cleared, stay IDLE.
- START: sampled 1 → OP. Sampled 0 → IDLE with counter cleared.
- OP: captures 2 bits MSB first. 10 = read, 01 = write. 00/11 → IDLE with counter cleared.
- PHYAD: 5 bits MSB first. REGAD: 5 bits MSB first, loaded into reg_addr.
- At the rise that samples REGAD bit 0:
  - If PHYAD matches PHY_ADDR and OP is read, reg_rd_en = 1 in the next cycle. reg_rd_data is latched one cycle later.
  - If PHYAD does not match, go to SKIP. SKIP counts 18 rises, then → IDLE and issues no strobes.
- TA, read:
  - 1st rise in TA (TA1 sampled, line Z): next cycle mdio_tri = 0, mdio_o = 0.
  - 2nd rise: next cycle drive D15 → RD_DATA.
- RD_DATA: each following rise shifts out the next bit, D14..D0. On the 16th rise after the TA2 rise, set mdio_tri = 1 and mdio_o = 1 next cycle → IDLE with counter cleared.
- TA, write: TA1 must sample 1 and TA2 must sample 0, otherwise → IDLE with counter cleared and no write. Then → WR_DATA.
- WR_DATA: 16 bits MSB first. The cycle after the rise sampling D0, reg_wr_en = 1 for one cycle with reg_wr_data → IDLE with counter cleared.
- Every completed or aborted frame needs a fresh preamble before the next one.
- mdio_tri = 0 only in TA2/RD_DATA of a matching read.

## Timing
- Reset values: mdio_o = 1, mdio_tri = 1, reg_rd_en = 0, reg_wr_en = 0, reg_addr = 0, reg_wr_data = 0, state IDLE, counter 0.
- Reset mid-frame releases the line immediately, because reset is asynchronous.
- Pin-to-sample latency: a mdc pin rise produces the rise pulse 3 cycles later. Drive changes are registered, so MDIO changes 4 axi_aclk cycles after the pin rise.
- Read strobe occurs 1 cycle after the REGAD0 rise. Data is latched 2 cycles after that rise, well before the TA2 rise.
- reg_rd_en and reg_wr_en are never asserted in the same cycle. Each is asserted at most once per frame.

## Test plan
- Reset: hold axi_aresetn = 0 for 5 cycles → all outputs at reset values. No strobes for 100 idle MDC periods with mdio_i = 1.
- Write: 32 ones, 01 01 00001 00101 10 0xBEEF → exactly one reg_wr_en, reg_addr = 5, reg_wr_data = 0xBEEF. mdio_tri stays 1 throughout.
- Read: 32 ones, 01 10 00001 00011, reg_rd_data = 0xA5C3 → one reg_rd_en with reg_addr = 3. Manager samples Z then 0 during TA, then 1010010111000011. mdio_tri = 1 after the D0 rise.
- Address mismatch or short preamble: read to PHYAD 2, and a separate read with 31 preamble ones → no strobes, mdio_tri constantly 1. A following valid frame is decoded normally.
- Bad TA: write frame with TA = 11 → no reg_wr_en. The next valid write succeeds.
- Reset mid-read: assert axi_aresetn during D8 → mdio_tri = 1 within the same cycle, no further strobes. A new read after release returns correct data.
